// File: rtl/rob_ctrl_pkg.sv
// rob_ctrl_pkg: shared ROB types and the trap-cause encoding helper.
package rob_ctrl_pkg;
   localparam int ROB_IW = 7;
   typedef logic [ROB_IW-1:0] rob_id_t;
   typedef struct packed {
      logic [7:0]  cause;
      logic        flush;
      logic [63:0] npc;
   } rob_cmp_t;
   // Interrupt flag lands in the MSB, the code in the low bits.
   function automatic logic [63:0] exc_code(input logic [6:0] c);
      return {c[6], 57'b0, c[5:0]};
   endfunction
endpackage

// File: rtl/rob_ctrl_if.sv
// rob_ctrl_if: rename/execute/commit/redirect signals of the reorder buffer.
interface rob_ctrl_if #(
   parameter int AWD = 4,
   parameter int EWD = 4,
   parameter int CWD = 4,
   parameter int IW  = 7
);
   logic [AWD-1:0]         alloc_valid;
   logic [AWD-1:0][63:0]   alloc_pc;
   logic                   alloc_ready;
   logic [AWD-1:0][IW-1:0] alloc_id;
   logic [EWD-1:0]         cmp_valid;
   logic [EWD-1:0][IW-1:0] cmp_id;
   logic [EWD-1:0][7:0]    cmp_cause;
   logic [EWD-1:0]         cmp_flush;
   logic [EWD-1:0][63:0]   cmp_npc;
   logic                   squash_valid;
   logic [IW-1:0]          squash_id;
   logic [63:0]            tvec;
   logic [CWD-1:0]         com_valid;
   logic [CWD-1:0][IW-1:0] com_id;
   logic [CWD-1:0][63:0]   com_pc;
   logic [CWD-1:0][63:0]   com_npc;
   logic                   redir_valid;
   logic [63:0]            redir_pc;
   logic                   exc_valid;
   logic [63:0]            exc_pc;
   logic [63:0]            exc_cause;
   logic [IW-1:0]          count;
   modport master (
      output alloc_valid, alloc_pc, cmp_valid, cmp_id, cmp_cause, cmp_flush, cmp_npc,
             squash_valid, squash_id, tvec,
      input  alloc_ready, alloc_id, com_valid, com_id, com_pc, com_npc, redir_valid,
             redir_pc, exc_valid, exc_pc, exc_cause, count
   );
   modport slave (
      input  alloc_valid, alloc_pc, cmp_valid, cmp_id, cmp_cause, cmp_flush, cmp_npc,
             squash_valid, squash_id, tvec,
      output alloc_ready, alloc_id, com_valid, com_id, com_pc, com_npc, redir_valid,
             redir_pc, exc_valid, exc_pc, exc_cause, count
   );
endinterface

// File: rtl/rob_ctrl_mwpram.sv
// rob_ctrl_mwpram: flop-based multi-write, multi-read payload store with async reads.
module rob_ctrl_mwpram #(
   parameter int NW    = 4,
   parameter int NR    = 4,
   parameter int DEPTH = 64,
   parameter int W     = 64,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic [NW-1:0]         we,
   input  logic [NW-1:0][AW-1:0] waddr,
   input  logic [NW-1:0][W-1:0]  wdata,
   input  logic [NR-1:0][AW-1:0] raddr,
   output logic [NR-1:0][W-1:0]  rdata
);
   logic [W-1:0] mem [DEPTH];
   // Later ports overwrite earlier ones on an address collision.
   always_ff @(posedge clk) begin
      for (int p = 0; p < NW; p++)
         if (we[p]) mem[waddr[p]] <= wdata[p];
   end
   for (genvar r = 0; r < NR; r++) begin : g_rd
      assign rdata[r] = mem[raddr[r]];
   end
endmodule

// File: rtl/rob_ctrl.sv
// rob_ctrl: reorder-buffer controller with multi-lane allocate, out-of-order completion,
// in-order multi-lane commit, partial squash and precise exception/flush redirect.
module rob_ctrl
   import rob_ctrl_pkg::*;
#(
   parameter int AWD   = 4,
   parameter int EWD   = 4,
   parameter int CWD   = 4,
   parameter int DEPTH = 64,
   parameter int IW    = $clog2(DEPTH) + 1
) (
   input logic       clk,
   input logic       rst,
   rob_ctrl_if.slave rob
);
   localparam int AW = IW - 1;
   logic [IW-1:0] head, tail, count, k, ncom, sq_age, lim;
   logic [DEPTH-1:0] busy, done, done_set, alloc_m, ret_m, drop_m;
   logic [AW-1:0] hoff, toff;
   logic [EWD-1:0] cmp_live;
   logic [AWD-1:0] pc_we;
   logic [AWD-1:0][AW-1:0] pc_wa;
   logic [EWD-1:0][AW-1:0] cmp_wa;
   logic [CWD-1:0][AW-1:0] ra;
   logic [CWD-1:0][63:0] pc_rd;
   rob_cmp_t [EWD-1:0] cmp_wd;
   rob_cmp_t [CWD-1:0] cmp_rd;
   logic [CWD-1:0] com_v;
   logic sq_live, exc_hit, flush_hit, redir, alloc_fire, run, arun;
   logic [63:0] hit_pc, hit_npc;
   logic [6:0] hit_cause;
   assign count = tail - head;
   assign sq_age = rob.squash_id - head;
   assign sq_live = !rst && rob.squash_valid && sq_age < count;
   // A live squash also caps commit so nothing younger than squash_id retires.
   assign lim = sq_live ? sq_age + IW'(1) : count;
   assign redir = exc_hit | flush_hit;
   assign alloc_fire = rob.alloc_valid[0] && rob.alloc_ready;
   assign rob.alloc_ready = !rst && !rob.squash_valid && !redir && IW'(DEPTH) - count >= IW'(AWD);
   assign rob.count = rst ? '0 : count;
   assign rob.redir_valid = redir;
   assign rob.redir_pc = exc_hit ? rob.tvec : flush_hit ? hit_npc : '0;
   assign rob.exc_valid = exc_hit;
   assign rob.exc_pc = exc_hit ? hit_pc : '0;
   assign rob.exc_cause = exc_hit ? exc_code(hit_cause) : '0;
   always_comb begin
      k = '0;
      arun = 1'b1;
      for (int i = 0; i < AWD; i++) begin
         arun = arun && rob.alloc_valid[i];
         k = arun ? k + IW'(1) : k;
      end
   end
   for (genvar g = 0; g < AWD; g++) begin : g_alloc
      assign pc_wa[g] = tail[AW-1:0] + AW'(g);
      assign pc_we[g] = alloc_fire && IW'(g) < k;
      assign rob.alloc_id[g] = rst ? '0 : tail + IW'(g);
   end
   for (genvar g = 0; g < EWD; g++) begin : g_cmp
      assign cmp_live[g] = !rst && rob.cmp_valid[g] && rob.cmp_id[g] - head < count;
      assign cmp_wa[g] = rob.cmp_id[g][AW-1:0];
      assign cmp_wd[g] = {rob.cmp_cause[g], rob.cmp_flush[g], rob.cmp_npc[g]};
   end
   for (genvar g = 0; g < CWD; g++) begin : g_com
      assign ra[g] = head[AW-1:0] + AW'(g);
      assign rob.com_valid[g] = com_v[g];
      assign rob.com_id[g] = com_v[g] ? head + IW'(g) : '0;
      assign rob.com_pc[g] = com_v[g] ? pc_rd[g] : '0;
      assign rob.com_npc[g] = com_v[g] ? cmp_rd[g].npc : '0;
   end
   // Walk lanes from the head; the first exception or flush ends the group.
   always_comb begin
      com_v = '0;
      exc_hit = 1'b0;
      flush_hit = 1'b0;
      hit_pc = '0;
      hit_npc = '0;
      hit_cause = '0;
      ncom = '0;
      run = !rst;
      for (int i = 0; i < CWD; i++) begin
         run = run && IW'(i) < lim && done[ra[i]] && busy[ra[i]];
         if (run) begin
            exc_hit = cmp_rd[i].cause[7];
            flush_hit = !exc_hit && cmp_rd[i].flush;
            com_v[i] = !exc_hit;
            ncom = exc_hit ? ncom : ncom + IW'(1);
            hit_pc = pc_rd[i];
            hit_npc = cmp_rd[i].npc;
            hit_cause = cmp_rd[i].cause[6:0];
            run = !exc_hit && !flush_hit;
         end
      end
   end
   always_comb begin
      hoff = '0;
      toff = '0;
      done_set = '0;
      for (int j = 0; j < DEPTH; j++) begin
         hoff = AW'(j) - head[AW-1:0];
         toff = AW'(j) - tail[AW-1:0];
         alloc_m[j] = alloc_fire && {1'b0, toff} < k;
         ret_m[j] = {1'b0, hoff} < ncom;
         drop_m[j] = sq_live && {1'b0, hoff} > sq_age && {1'b0, hoff} < count;
      end
      for (int p = 0; p < EWD; p++)
         if (cmp_live[p]) done_set[cmp_wa[p]] = 1'b1;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         head <= '0;
         tail <= '0;
         busy <= '0;
         done <= '0;
      end else begin
         head <= redir ? tail : head + ncom;
         tail <= redir ? tail : sq_live ? rob.squash_id + IW'(1) : alloc_fire ? tail + k : tail;
         busy <= redir ? '0 : ~drop_m & (alloc_m | (busy & ~ret_m));
         done <= ~alloc_m & (done | done_set);
      end
   end
   rob_ctrl_mwpram #(.NW(AWD), .NR(CWD), .DEPTH(DEPTH), .W(64)) u_pc (
      .clk(clk), .we(pc_we), .waddr(pc_wa), .wdata(rob.alloc_pc), .raddr(ra), .rdata(pc_rd)
   );
   rob_ctrl_mwpram #(.NW(EWD), .NR(CWD), .DEPTH(DEPTH), .W($bits(rob_cmp_t))) u_cmp (
      .clk(clk), .we(cmp_live), .waddr(cmp_wa), .wdata(cmp_wd), .raddr(ra), .rdata(cmp_rd)
   );
endmodule

// File: tb/tb_rob_ctrl.sv
// tb_rob_ctrl: directed scenarios for rob_ctrl with hand-derived expectations.
module tb_rob_ctrl;
   localparam logic [63:0] TVEC = 64'hffff_0000_0000_0100;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int passed = 0;
   int total = 0;
   rob_ctrl_if bus ();
   rob_ctrl dut (.clk(clk), .rst(rst), .rob(bus));
   always #5 clk = ~clk;

   function automatic logic [63:0] pcof(input int n);
      return 64'h1000 + 64'(n) * 4;
   endfunction
   function automatic logic [63:0] spc(input int n);
      return 64'h4000_0000 + 64'(n) * 4;
   endfunction

   task automatic idle;
      bus.alloc_valid = '0;
      bus.alloc_pc = '0;
      bus.cmp_valid = '0;
      bus.cmp_id = '0;
      bus.cmp_cause = '0;
      bus.cmp_flush = '0;
      bus.cmp_npc = '0;
      bus.squash_valid = 1'b0;
      bus.squash_id = '0;
      bus.tvec = TVEC;
   endtask
   // Let the edge take the driven inputs, then return idle and settle.
   task automatic step;
      @(posedge clk);
      #1;
      idle();
      #1;
   endtask
   task automatic reset_dut;
      rst = 1'b1;
      idle();
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
   endtask
   task automatic alloc_burst(input int base, input int n);
      bus.alloc_valid = 4'((1 << n) - 1);
      for (int i = 0; i < 4; i++) bus.alloc_pc[i] = pcof(base + i);
      step();
   endtask

   task automatic test_reset;
      rst = 1'b1;
      idle();
      @(posedge clk);
      #1;
      bus.alloc_valid = 4'hf;
      bus.squash_valid = 1'b1;
      #1;
      total++; if (bus.alloc_ready !== 1'b0) $display("FAIL reset_ready got %b want 0", bus.alloc_ready); else passed++;
      total++; if (bus.count !== 7'd0) $display("FAIL reset_count got %0d want 0", bus.count); else passed++;
      total++; if (bus.com_valid !== 4'h0 || bus.redir_valid !== 1'b0 || bus.exc_valid !== 1'b0)
         $display("FAIL reset_outs got com=%b redir=%b exc=%b want 0", bus.com_valid, bus.redir_valid, bus.exc_valid); else passed++;
      @(posedge clk);
      #1;
      rst = 1'b0;
      idle();
      #1;
      total++; if (bus.alloc_ready !== 1'b1) $display("FAIL post_reset_ready got %b want 1", bus.alloc_ready); else passed++;
      total++; if (bus.alloc_id[0] !== 7'd0 || bus.count !== 7'd0)
         $display("FAIL post_reset_ptr got id=%0d count=%0d want 0 0", bus.alloc_id[0], bus.count); else passed++;
   endtask

   task automatic test_fill;
      reset_dut();
      for (int b = 0; b < 16; b++) begin
         total++;
         if (bus.alloc_ready !== 1'b1 || bus.alloc_id[0] !== 7'(4 * b) || bus.alloc_id[3] !== 7'(4 * b + 3))
            $display("FAIL fill_burst%0d got rdy=%b id0=%0d id3=%0d want 1 %0d %0d", b, bus.alloc_ready,
                     bus.alloc_id[0], bus.alloc_id[3], 4 * b, 4 * b + 3);
         else passed++;
         alloc_burst(4 * b, 4);
      end
      total++; if (bus.alloc_ready !== 1'b0) $display("FAIL full_ready got %b want 0", bus.alloc_ready); else passed++;
      total++; if (bus.count !== 7'd64) $display("FAIL full_count got %0d want 64", bus.count); else passed++;
      bus.alloc_valid = 4'hf;
      step();
      total++; if (bus.count !== 7'd64) $display("FAIL full_alloc_count got %0d want 64", bus.count); else passed++;
   endtask

   task automatic test_reverse;
      for (int id = 3; id >= 0; id--) begin
         bus.cmp_valid = 4'b0001;
         bus.cmp_id[0] = 7'(id);
         bus.cmp_npc[0] = 64'h2000 + 64'(id);
         #1;
         total++; if (bus.com_valid !== 4'h0) $display("FAIL rev_pre%0d got %b want 0000", id, bus.com_valid); else passed++;
         step();
         if (id > 0) begin
            total++; if (bus.com_valid !== 4'h0) $display("FAIL rev_post%0d got %b want 0000", id, bus.com_valid); else passed++;
         end
      end
      total++; if (bus.com_valid !== 4'hf) $display("FAIL rev_commit got %b want 1111", bus.com_valid); else passed++;
      for (int i = 0; i < 4; i++) begin
         total++;
         if (bus.com_id[i] !== 7'(i) || bus.com_pc[i] !== pcof(i) || bus.com_npc[i] !== 64'h2000 + 64'(i))
            $display("FAIL rev_lane%0d got id=%0d pc=%h npc=%h want %0d %h %h", i, bus.com_id[i], bus.com_pc[i],
                     bus.com_npc[i], i, pcof(i), 64'h2000 + 64'(i));
         else passed++;
      end
      step();
      total++; if (bus.count !== 7'd60) $display("FAIL rev_count got %0d want 60", bus.count); else passed++;
   endtask

   task automatic test_exception;
      reset_dut();
      alloc_burst(0, 4);
      alloc_burst(4, 4);
      alloc_burst(8, 2);
      bus.cmp_valid = 4'b0111;
      bus.cmp_id[0] = 7'd0;
      bus.cmp_id[1] = 7'd1;
      bus.cmp_id[2] = 7'd2;
      bus.cmp_cause[2] = 8'h82;
      step();
      total++; if (bus.com_valid !== 4'b0011) $display("FAIL exc_com got %b want 0011", bus.com_valid); else passed++;
      total++; if (bus.exc_valid !== 1'b1 || bus.exc_pc !== pcof(2))
         $display("FAIL exc_pc got v=%b pc=%h want 1 %h", bus.exc_valid, bus.exc_pc, pcof(2)); else passed++;
      total++; if (bus.exc_cause !== 64'h2) $display("FAIL exc_cause got %h want 2", bus.exc_cause); else passed++;
      total++; if (bus.redir_valid !== 1'b1 || bus.redir_pc !== TVEC)
         $display("FAIL exc_redir got v=%b pc=%h want 1 %h", bus.redir_valid, bus.redir_pc, TVEC); else passed++;
      total++; if (bus.alloc_ready !== 1'b0) $display("FAIL exc_ready got %b want 0", bus.alloc_ready); else passed++;
      step();
      total++; if (bus.count !== 7'd0 || bus.exc_valid !== 1'b0)
         $display("FAIL exc_after got count=%0d exc=%b want 0 0", bus.count, bus.exc_valid); else passed++;
      total++; if (bus.alloc_id[0] !== 7'd10) $display("FAIL exc_tail got %0d want 10", bus.alloc_id[0]); else passed++;
   endtask

   task automatic test_squash;
      reset_dut();
      for (int b = 0; b < 5; b++) alloc_burst(4 * b, 4);
      bus.squash_valid = 1'b1;
      bus.squash_id = 7'd5;
      bus.alloc_valid = 4'hf;
      #1;
      total++; if (bus.alloc_ready !== 1'b0) $display("FAIL sq_ready got %b want 0", bus.alloc_ready); else passed++;
      step();
      total++; if (bus.count !== 7'd6 || bus.alloc_id[0] !== 7'd6)
         $display("FAIL sq_tail got count=%0d id=%0d want 6 6", bus.count, bus.alloc_id[0]); else passed++;
      bus.cmp_valid = 4'b0001;
      bus.cmp_id[0] = 7'd9;
      step();
      total++; if (bus.count !== 7'd6 || bus.com_valid !== 4'h0)
         $display("FAIL sq_stale got count=%0d com=%b want 6 0000", bus.count, bus.com_valid); else passed++;
      bus.cmp_valid = 4'hf;
      for (int p = 0; p < 4; p++) bus.cmp_id[p] = 7'(p);
      step();
      total++; if (bus.com_valid !== 4'hf) $display("FAIL sq_com1 got %b want 1111", bus.com_valid); else passed++;
      bus.cmp_valid = 4'b0011;
      bus.cmp_id[0] = 7'd4;
      bus.cmp_id[1] = 7'd5;
      step();
      total++; if (bus.com_valid !== 4'b0011 || bus.com_id[1] !== 7'd5)
         $display("FAIL sq_com2 got %b id1=%0d want 0011 5", bus.com_valid, bus.com_id[1]); else passed++;
      step();
      total++; if (bus.count !== 7'd0) $display("FAIL sq_drain got %0d want 0", bus.count); else passed++;
   endtask

   task automatic test_flush;
      reset_dut();
      alloc_burst(0, 4);
      alloc_burst(4, 4);
      bus.cmp_valid = 4'b0001;
      bus.cmp_id[0] = 7'd0;
      bus.cmp_flush[0] = 1'b1;
      bus.cmp_npc[0] = 64'h8000_1000;
      step();
      bus.squash_valid = 1'b1;
      bus.squash_id = 7'd3;
      #1;
      total++; if (bus.com_valid !== 4'b0001 || bus.com_id[0] !== 7'd0)
         $display("FAIL fl_com got %b id=%0d want 0001 0", bus.com_valid, bus.com_id[0]); else passed++;
      total++; if (bus.redir_valid !== 1'b1 || bus.redir_pc !== 64'h8000_1000)
         $display("FAIL fl_redir got v=%b pc=%h want 1 80001000", bus.redir_valid, bus.redir_pc); else passed++;
      total++; if (bus.exc_valid !== 1'b0 || bus.alloc_ready !== 1'b0)
         $display("FAIL fl_side got exc=%b rdy=%b want 0 0", bus.exc_valid, bus.alloc_ready); else passed++;
      step();
      total++; if (bus.count !== 7'd0 || bus.redir_valid !== 1'b0)
         $display("FAIL fl_after got count=%0d redir=%b want 0 0", bus.count, bus.redir_valid); else passed++;
   endtask

   task automatic test_stream;
      int a, cp, ex, cyc, ncm;
      logic [3:0] cv;
      a = 0;
      cp = 0;
      ex = 0;
      cyc = 0;
      reset_dut();
      while (ex < 200 && cyc < 2000) begin
         cv = bus.com_valid;
         total++; if ((cv & (cv + 4'd1)) !== 4'd0) $display("FAIL stream_gap got %b", cv); else passed++;
         for (int i = 0; i < 4; i++) begin
            if (cv[i]) begin
               total++;
               if (bus.com_id[i] !== 7'(ex) || bus.com_pc[i] !== spc(ex))
                  $display("FAIL stream_order got id=%0d pc=%h want %0d %h", bus.com_id[i], bus.com_pc[i], 7'(ex), spc(ex));
               else passed++;
               ex++;
            end
         end
         ncm = (cyc % 3 == 0) ? 1 : 4;
         if (ncm > a - cp) ncm = a - cp;
         for (int p = 0; p < ncm; p++) begin
            bus.cmp_valid[p] = 1'b1;
            bus.cmp_id[p] = 7'(cp + ncm - 1 - p);
         end
         cp += ncm;
         if (bus.alloc_ready && a < 200) begin
            bus.alloc_valid = 4'hf;
            for (int i = 0; i < 4; i++) bus.alloc_pc[i] = spc(a + i);
            a += 4;
         end
         step();
         cyc++;
      end
      total++; if (ex != 200) $display("FAIL stream_done got %0d want 200", ex); else passed++;
      step();
      total++; if (bus.count !== 7'd0) $display("FAIL stream_count got %0d want 0", bus.count); else passed++;
   endtask

   initial begin
      idle();
      test_reset();
      test_fill();
      test_reverse();
      test_exception();
      test_squash();
      test_flush();
      test_stream();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout after %0d/%0d", passed, total);
      $fatal(1);
   end
endmodule
